// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset vector and exception bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_CANCEL = 2'd3
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    localparam int EXC_W       = 8;
    localparam int EXC_ADEL_IF = 7;

endpackage

// File: rtl/pc_next_sel.sv
// Next fetch address: flush target, then branch resolved this cycle, then recorded branch, then pc+4.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic [31:0] pcplus4
);

    assign pcplus4 = pc + INST_BYTES;

    always_comb begin
        if (flush) begin
            next_pc = flush_pc;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end else begin
            next_pc = pcplus4;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage driving an SRAM-like fetch bus.
// Define IF_ADDR_CHECK_EN to raise fetch AdEL on misaligned PCs instead of fetching them.
//
// state    | meaning
// S_REQ    | request pending, waiting for addr_ok
// S_WAIT   | request accepted, waiting for data_ok
// S_HOLD   | instruction latched while the pipeline is stalled
// S_CANCEL | flushed; discard the one response still in flight
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [31:0]       flush_pc_i,
    input  logic              branch_taken_i,
    input  logic [31:0]       branch_target_i,
    input  logic              id_is_branch_i,
    output logic              inst_req_o,
    output logic [31:0]       inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [31:0]       inst_rdata_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       pcplus4_o,
    output logic [31:0]       instr_o,
    output logic [EXC_W-1:0]  except_o,
    output logic              is_in_delayslot_o,
    output logic              fetch_stall_o
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_tgt_q, br_tgt_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_ds_q, hold_ds_d;
    logic        advance;
    logic        addr_err;

`ifdef IF_ADDR_CHECK_EN
    assign addr_err = (state_q == S_REQ) && (pc_q[1:0] != 2'b00);
`else
    assign addr_err = 1'b0;
`endif

    pc_next_sel u_pc_next_sel (
        .flush         (flush_i),
        .flush_pc      (flush_pc_i),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .pend_valid    (br_pend_q),
        .pend_target   (br_tgt_q),
        .pc            (pc_q),
        .next_pc       (next_pc),
        .pcplus4       (pcplus4_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            br_pend_q   <= 1'b0;
            br_tgt_q    <= '0;
            hold_data_q <= '0;
            hold_ds_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            br_pend_q   <= br_pend_d;
            br_tgt_q    <= br_tgt_d;
            hold_data_q <= hold_data_d;
            hold_ds_q   <= hold_ds_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        hold_data_d       = hold_data_q;
        hold_ds_d         = hold_ds_q;
        advance           = 1'b0;
        inst_req_o        = 1'b0;
        instr_o           = '0;
        is_in_delayslot_o = 1'b0;
        fetch_stall_o     = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (addr_err) begin
                    // faulting slot: bubble delivered so the exception can travel down the pipe
                    is_in_delayslot_o = id_is_branch_i;
                    advance           = !flush_i && !stall_i;
                end else begin
                    inst_req_o    = 1'b1;
                    fetch_stall_o = 1'b1;
                    if (inst_addr_ok_i) begin
                        state_d = flush_i ? S_CANCEL : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (inst_data_ok_i) begin
                    instr_o           = inst_rdata_i;
                    is_in_delayslot_o = id_is_branch_i;
                    if (flush_i || !stall_i) begin
                        advance = !flush_i;
                        state_d = S_REQ;
                    end else begin
                        hold_data_d = inst_rdata_i;
                        hold_ds_d   = id_is_branch_i;
                        state_d     = S_HOLD;
                    end
                end else begin
                    fetch_stall_o = 1'b1;
                    if (flush_i) begin
                        state_d = S_CANCEL;
                    end
                end
            end
            S_HOLD: begin
                instr_o           = hold_data_q;
                is_in_delayslot_o = hold_ds_q;
                if (flush_i || !stall_i) begin
                    advance = !flush_i;
                    state_d = S_REQ;
                end
            end
            S_CANCEL: begin
                fetch_stall_o = 1'b1;
                if (inst_data_ok_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        pc_d = (flush_i || advance) ? next_pc : pc_q;

        br_pend_d = br_pend_q;
        br_tgt_d  = br_tgt_q;
        if (flush_i || advance) begin
            br_pend_d = 1'b0;
        end else if (branch_taken_i) begin
            br_pend_d = 1'b1;
            br_tgt_d  = branch_target_i;
        end
    end

    always_comb begin
        except_o              = '0;
        except_o[EXC_ADEL_IF] = addr_err;
    end

    assign inst_addr_o = pc_q;
    assign pc_o        = pc_q;

endmodule
